reorder_buffer: RTL and testbench

Parametrised, multi-commit reorder buffer for the tartaruga in-order pipeline. Decode allocates one entry per cycle. The writeback stage marks entries complete with their result. Up to COMMIT_WIDTH oldest completed entries retire per cycle in program order, and a taken branch at commit flushes every younger entry. It also provides NUM_SRC register-hazard lookup ports for decode forwarding and stall decisions.

---
 rtl/tartaruga_pkg.sv | 26 ++
 rtl/rob_lookup.sv | 46 ++++
 rtl/reorder_buffer.sv | 187 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types and defaults for the tartaruga reorder buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ROB_DEPTH / ROB_COMMIT_WIDTH defaults, rob_idx_t, rob_entry_t.
package tartaruga_pkg;

  localparam int ROB_DEPTH        = 8;
  localparam int ROB_COMMIT_WIDTH = 2;
  localparam int ROB_IDX_W        = $clog2(ROB_DEPTH);

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic        valid;
    logic        completed;
    logic        branch;     // completed as a taken branch
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic        store;
    logic [31:0] result;
    logic [31:0] new_pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_lookup.sv
// Youngest-writer search over the ROB for one source register.
// Latency: combinational from registered ROB state (no writeback bypass).
// Backpressure: none; pure lookup.
// Ports: i_tail (next alloc slot), i_addr (source reg), per-entry i_wr_vld/i_rd/
//        i_cmpl/i_result; o_hazard/o_completed/o_idx/o_result for the match.
module rob_lookup #(
  parameter int DEPTH = 8,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic [IW-1:0]    i_tail,
  input  logic [4:0]       i_addr,
  input  logic [DEPTH-1:0] i_wr_vld,
  input  logic [4:0]       i_rd     [DEPTH],
  input  logic [DEPTH-1:0] i_cmpl,
  input  logic [31:0]      i_result [DEPTH],
  output logic             o_hazard,
  output logic             o_completed,
  output logic [IW-1:0]    o_idx,
  output logic [31:0]      o_result
);

  logic [IW-1:0] w_pos;
  logic          w_found;

  // Walk backwards from tail-1; the first hit is the youngest writer.
  // k == DEPTH lands on tail itself, which only holds a live entry when full.
  always_comb begin
    w_found     = 1'b0;
    w_pos       = '0;
    o_hazard    = 1'b0;
    o_completed = 1'b0;
    o_idx       = '0;
    o_result    = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_pos = i_tail - IW'(k);
      if (!w_found && (i_addr != 5'd0) && i_wr_vld[w_pos] && (i_rd[w_pos] == i_addr)) begin
        w_found     = 1'b1;
        o_hazard    = 1'b1;
        o_completed = i_cmpl[w_pos];
        o_idx       = w_pos;
        o_result    = i_result[w_pos];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Multi-commit reorder buffer: in-order alloc, out-of-order complete, in-order retire.
// Latency: complete at edge M -> retire visible in cycle M+1; flush clears on next edge.
// Backpressure: decode stalls on full_o; a full buffer still accepts alloc when head retires.
// Ports: alloc_* (decode), wb_* (writeback), src_* (hazard lookup), commit_* / flush_* (retire).
module reorder_buffer
  import tartaruga_pkg::*;
#(
  parameter int DEPTH        = ROB_DEPTH,
  parameter int COMMIT_WIDTH = ROB_COMMIT_WIDTH,
  parameter int NUM_SRC      = 2,
  localparam int IW          = $clog2(DEPTH),
  localparam int CW          = IW + 1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      alloc_valid_i,
  input  logic [31:0]               alloc_pc_i,
  input  logic [31:0]               alloc_instr_i,
  input  logic [4:0]                alloc_rd_i,
  input  logic                      alloc_we_i,
  input  logic                      alloc_store_i,
  output logic [IW-1:0]             alloc_idx_o,
  output logic                      full_o,
  input  logic                      wb_valid_i,
  input  logic [IW-1:0]             wb_idx_i,
  input  logic [31:0]               wb_result_i,
  input  logic                      wb_branch_taken_i,
  input  logic [31:0]               wb_new_pc_i,
  input  logic [NUM_SRC*5-1:0]      src_addr_i,
  output logic [NUM_SRC-1:0]        src_hazard_o,
  output logic [NUM_SRC-1:0]        src_completed_o,
  output logic [NUM_SRC*IW-1:0]     src_idx_o,
  output logic [NUM_SRC*32-1:0]     src_result_o,
  output logic [COMMIT_WIDTH-1:0]   commit_valid_o,
  output logic [COMMIT_WIDTH*32-1:0] commit_pc_o,
  output logic [COMMIT_WIDTH*32-1:0] commit_instr_o,
  output logic [COMMIT_WIDTH*32-1:0] commit_result_o,
  output logic [COMMIT_WIDTH*5-1:0] commit_rd_o,
  output logic [COMMIT_WIDTH-1:0]   commit_we_o,
  output logic [COMMIT_WIDTH-1:0]   commit_store_o,
  output logic                      flush_o,
  output logic [31:0]               flush_pc_o
);

  rob_entry_t        r_entries [DEPTH];
  logic [IW-1:0]     r_head;
  logic [IW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [COMMIT_WIDTH-1:0] w_commit;
  logic [IW-1:0]     w_lane_idx [COMMIT_WIDTH];
  logic [1:0]        w_nret;
  logic              w_chain;
  logic              w_flush;
  logic [31:0]       w_flush_pc;
  logic              w_alloc;
  logic              w_wb;
  rob_entry_t        w_new;

  // Retire selection: lanes stop at the first not-ready entry or after a taken branch.
  always_comb begin
    w_commit   = '0;
    w_nret     = '0;
    w_chain    = 1'b1;
    w_flush    = 1'b0;
    w_flush_pc = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      w_lane_idx[k] = r_head + IW'(k);
      if (w_chain && r_entries[w_lane_idx[k]].valid && r_entries[w_lane_idx[k]].completed) begin
        w_commit[k] = 1'b1;
        w_nret      = w_nret + 2'd1;
        if (r_entries[w_lane_idx[k]].branch) begin
          w_flush    = 1'b1;
          w_flush_pc = r_entries[w_lane_idx[k]].new_pc;
          w_chain    = 1'b0;
        end
      end else begin
        w_chain = 1'b0;
      end
    end
  end

  // When full, the head slot (== tail) frees up this cycle if anything retires.
  assign full_o      = (r_count == CW'(DEPTH));
  assign alloc_idx_o = r_tail;
  assign w_alloc     = alloc_valid_i && (!full_o || (w_nret != 2'd0)) && !w_flush;
  assign w_wb        = wb_valid_i && r_entries[wb_idx_i].valid && !w_flush;
  assign flush_o     = w_flush;
  assign flush_pc_o  = w_flush_pc;

  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.pc    = alloc_pc_i;
    w_new.instr = alloc_instr_i;
    w_new.rd    = alloc_rd_i;
    w_new.we    = alloc_we_i;
    w_new.store = alloc_store_i;
  end

  always_comb begin
    commit_valid_o  = w_commit;
    commit_pc_o     = '0;
    commit_instr_o  = '0;
    commit_result_o = '0;
    commit_rd_o     = '0;
    commit_we_o     = '0;
    commit_store_o  = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (w_commit[k]) begin
        commit_pc_o[k*32 +: 32]     = r_entries[w_lane_idx[k]].pc;
        commit_instr_o[k*32 +: 32]  = r_entries[w_lane_idx[k]].instr;
        commit_result_o[k*32 +: 32] = r_entries[w_lane_idx[k]].result;
        commit_rd_o[k*5 +: 5]       = r_entries[w_lane_idx[k]].rd;
        commit_we_o[k]              = r_entries[w_lane_idx[k]].we && (r_entries[w_lane_idx[k]].rd != 5'd0);
        commit_store_o[k]           = r_entries[w_lane_idx[k]].store;
      end
    end
  end

  // Order matters: completion, then retire-invalidate, then allocation, so an
  // allocation into the slot retiring this cycle wins.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i].valid     <= 1'b0;
        r_entries[i].completed <= 1'b0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wb) begin
        r_entries[wb_idx_i].completed <= 1'b1;
        r_entries[wb_idx_i].result    <= wb_result_i;
        r_entries[wb_idx_i].branch    <= wb_branch_taken_i;
        r_entries[wb_idx_i].new_pc    <= wb_new_pc_i;
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (w_commit[k]) begin
          r_entries[w_lane_idx[k]].valid     <= 1'b0;
          r_entries[w_lane_idx[k]].completed <= 1'b0;
        end
      end
      if (w_alloc) r_entries[r_tail] <= w_new;
      r_head  <= r_head + IW'(w_nret);
      r_tail  <= r_tail + IW'(w_alloc);
      r_count <= r_count + CW'(w_alloc) - CW'(w_nret);
    end
  end

  // Flattened per-entry views for the lookup ports.
  logic [DEPTH-1:0] w_wr_vld;
  logic [DEPTH-1:0] w_cmpl;
  logic [4:0]       w_rd  [DEPTH];
  logic [31:0]      w_res [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wr_vld[i] = r_entries[i].valid && r_entries[i].we;
      w_cmpl[i]   = r_entries[i].completed;
      w_rd[i]     = r_entries[i].rd;
      w_res[i]    = r_entries[i].result;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lookup
    rob_lookup #(.DEPTH(DEPTH)) u_lookup (
      .i_tail      (r_tail),
      .i_addr      (src_addr_i[g*5 +: 5]),
      .i_wr_vld    (w_wr_vld),
      .i_rd        (w_rd),
      .i_cmpl      (w_cmpl),
      .i_result    (w_res),
      .o_hazard    (src_hazard_o[g]),
      .o_completed (src_completed_o[g]),
      .o_idx       (src_idx_o[g*IW +: IW]),
      .o_result    (src_result_o[g*32 +: 32])
    );
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer (DEPTH=8, COMMIT_WIDTH=2, NUM_SRC=2).
// Retirements are checked by a scoreboard monitor; state/lookup outputs inline.
// Clock period 10; inputs change 1 time unit after posedge, monitor samples at negedge.
module tb_reorder_buffer;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        alloc_valid_i = 1'b0;
  logic [31:0] alloc_pc_i = '0;
  logic [31:0] alloc_instr_i = '0;
  logic [4:0]  alloc_rd_i = '0;
  logic        alloc_we_i = 1'b0;
  logic        alloc_store_i = 1'b0;
  logic [2:0]  alloc_idx_o;
  logic        full_o;
  logic        wb_valid_i = 1'b0;
  logic [2:0]  wb_idx_i = '0;
  logic [31:0] wb_result_i = '0;
  logic        wb_branch_taken_i = 1'b0;
  logic [31:0] wb_new_pc_i = '0;
  logic [9:0]  src_addr_i = '0;
  logic [1:0]  src_hazard_o;
  logic [1:0]  src_completed_o;
  logic [5:0]  src_idx_o;
  logic [63:0] src_result_o;
  logic [1:0]  commit_valid_o;
  logic [63:0] commit_pc_o;
  logic [63:0] commit_instr_o;
  logic [63:0] commit_result_o;
  logic [9:0]  commit_rd_o;
  logic [1:0]  commit_we_o;
  logic [1:0]  commit_store_o;
  logic        flush_o;
  logic [31:0] flush_pc_o;

  reorder_buffer #(.DEPTH(8), .COMMIT_WIDTH(2), .NUM_SRC(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i), .alloc_instr_i(alloc_instr_i),
    .alloc_rd_i(alloc_rd_i), .alloc_we_i(alloc_we_i), .alloc_store_i(alloc_store_i),
    .alloc_idx_o(alloc_idx_o), .full_o(full_o),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_result_i(wb_result_i),
    .wb_branch_taken_i(wb_branch_taken_i), .wb_new_pc_i(wb_new_pc_i),
    .src_addr_i(src_addr_i), .src_hazard_o(src_hazard_o), .src_completed_o(src_completed_o),
    .src_idx_o(src_idx_o), .src_result_o(src_result_o),
    .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o), .commit_instr_o(commit_instr_o),
    .commit_result_o(commit_result_o), .commit_rd_o(commit_rd_o), .commit_we_o(commit_we_o),
    .commit_store_o(commit_store_o), .flush_o(flush_o), .flush_pc_o(flush_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          lane;
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic        store;
    logic        flush;
    logic [31:0] fpc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push(int lane, logic [31:0] pc, logic [31:0] res, logic [4:0] rd,
                               logic we, logic st, logic fl, logic [31:0] fpc);
    exp_t e;
    e.lane = lane; e.pc = pc; e.result = res; e.rd = rd;
    e.we = we; e.store = st; e.flush = fl; e.fpc = fpc;
    sb_q.push_back(e);
  endfunction

  // Retirement monitor.
  initial begin
    exp_t        e;
    logic        ef;
    logic [31:0] efpc;
    logic        any;
    forever begin
      @(negedge clk_i);
      if (rstn_i) begin
        ef = 1'b0; efpc = '0; any = 1'b0;
        for (int k = 0; k < 2; k++) begin
          if (commit_valid_o[k]) begin
            any = 1'b1;
            if (sb_q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL unexpected_commit: lane %0d pc 0x%0h, expected no retirement", k, commit_pc_o[k*32 +: 32]);
            end else begin
              e = sb_q.pop_front();
              chk("commit_lane",   k, e.lane);
              chk("commit_pc",     commit_pc_o[k*32 +: 32], e.pc);
              chk("commit_instr",  commit_instr_o[k*32 +: 32], ~e.pc);
              chk("commit_result", commit_result_o[k*32 +: 32], e.result);
              chk("commit_rd",     {27'd0, commit_rd_o[k*5 +: 5]}, {27'd0, e.rd});
              chk("commit_we",     {31'd0, commit_we_o[k]}, {31'd0, e.we});
              chk("commit_store",  {31'd0, commit_store_o[k]}, {31'd0, e.store});
              if (e.flush) begin ef = 1'b1; efpc = e.fpc; end
            end
          end
        end
        if (any) begin
          chk("flush_o", {31'd0, flush_o}, {31'd0, ef});
          chk("flush_pc", flush_pc_o, efpc);
        end else if (flush_o) begin
          n_cmp++; n_err++;
          $display("FAIL flush_without_commit: flush_o=1, expected 0");
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    alloc_valid_i = 1'b0; wb_valid_i = 1'b0; src_addr_i = '0;
    #2;
    chk("rst_alloc_idx", {29'd0, alloc_idx_o}, 32'd0);
    chk("rst_full", {31'd0, full_o}, 32'd0);
    chk("rst_commit_valid", {30'd0, commit_valid_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    tick();
    rstn_i = 1'b1;
  endtask

  task automatic alloc(logic [31:0] pc, logic [4:0] rd, logic we, logic st);
    alloc_valid_i = 1'b1; alloc_pc_i = pc; alloc_instr_i = ~pc;
    alloc_rd_i = rd; alloc_we_i = we; alloc_store_i = st;
    tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic complete(logic [2:0] idx, logic [31:0] res, logic br, logic [31:0] npc);
    wb_valid_i = 1'b1; wb_idx_i = idx; wb_result_i = res;
    wb_branch_taken_i = br; wb_new_pc_i = npc;
    tick();
    wb_valid_i = 1'b0; wb_branch_taken_i = 1'b0;
  endtask

  task automatic lookup(logic [4:0] a0, logic [4:0] a1);
    src_addr_i = {a1, a0};
    #1;
  endtask

  initial begin
    // ---- Fill to full, overflow ignored, then retire+alloc while full ----
    do_reset();
    lookup(5'd1, 5'd0);
    chk("rst_hazard", {30'd0, src_hazard_o}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      alloc(32'h100 + 32'(4 * i), 5'(i + 1), 1'b1, 1'b0);
      chk("fill_alloc_idx", {29'd0, alloc_idx_o}, 32'((i + 1) % 8));
    end
    chk("fill_full", {31'd0, full_o}, 32'd1);
    alloc(32'h999, 5'd20, 1'b1, 1'b0);
    chk("overflow_alloc_idx", {29'd0, alloc_idx_o}, 32'd0);
    chk("overflow_full", {31'd0, full_o}, 32'd1);
    lookup(5'd20, 5'd0);
    chk("overflow_no_entry", {31'd0, src_hazard_o[0]}, 32'd0);

    push(0, 32'h100, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    complete(3'd0, 32'h11, 1'b0, 32'h0);
    alloc(32'h200, 5'd9, 1'b1, 1'b0);
    chk("full_swap_full", {31'd0, full_o}, 32'd1);
    chk("full_swap_alloc_idx", {29'd0, alloc_idx_o}, 32'd1);
    lookup(5'd9, 5'd1);
    chk("full_swap_hazard", {31'd0, src_hazard_o[0]}, 32'd1);
    chk("full_swap_idx", {29'd0, src_idx_o[2:0]}, 32'd0);
    chk("full_swap_cmpl", {31'd0, src_completed_o[0]}, 32'd0);
    chk("retired_x1_gone", {31'd0, src_hazard_o[1]}, 32'd0);

    // ---- Out-of-order completion, dual retire ----
    do_reset();
    alloc(32'h300, 5'd5, 1'b1, 1'b0);
    alloc(32'h304, 5'd6, 1'b0, 1'b1);
    push(0, 32'h300, 32'h55, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0);
    push(1, 32'h304, 32'h66, 5'd6, 1'b0, 1'b1, 1'b0, 32'h0);
    complete(3'd1, 32'h66, 1'b0, 32'h0);
    tick(); tick();
    chk("ooo_pending", 32'(sb_q.size()), 32'd2);
    complete(3'd0, 32'h55, 1'b0, 32'h0);
    tick();
    chk("ooo_drained", 32'(sb_q.size()), 32'd0);
    chk("ooo_alloc_idx", {29'd0, alloc_idx_o}, 32'd2);

    // ---- Lookup: youngest writer, no same-cycle bypass ----
    do_reset();
    alloc(32'h10, 5'd1, 1'b1, 1'b0);
    alloc(32'h14, 5'd2, 1'b1, 1'b0);
    alloc(32'h18, 5'd3, 1'b1, 1'b0);
    alloc(32'h1c, 5'd7, 1'b1, 1'b0);
    alloc(32'h20, 5'd3, 1'b1, 1'b0);
    complete(3'd2, 32'hAA, 1'b0, 32'h0);
    lookup(5'd3, 5'd2);
    chk("lk_hazard", {30'd0, src_hazard_o}, 32'd3);
    chk("lk_idx0", {29'd0, src_idx_o[2:0]}, 32'd4);
    chk("lk_idx1", {29'd0, src_idx_o[5:3]}, 32'd1);
    chk("lk_cmpl0", {31'd0, src_completed_o[0]}, 32'd0);
    wb_valid_i = 1'b1; wb_idx_i = 3'd4; wb_result_i = 32'hBB;
    #1;
    chk("lk_no_bypass", {31'd0, src_completed_o[0]}, 32'd0);
    tick();
    wb_valid_i = 1'b0;
    #1;
    chk("lk_cmpl_after", {31'd0, src_completed_o[0]}, 32'd1);
    chk("lk_result", src_result_o[31:0], 32'hBB);
    chk("lk_idx_after", {29'd0, src_idx_o[2:0]}, 32'd4);

    // ---- Taken branch at head flushes a completed younger entry ----
    do_reset();
    alloc(32'h400, 5'd8, 1'b1, 1'b0);
    alloc(32'h404, 5'd9, 1'b1, 1'b0);
    alloc(32'h408, 5'd10, 1'b1, 1'b0);
    push(0, 32'h400, 32'h44, 5'd8, 1'b1, 1'b0, 1'b1, 32'h80);
    complete(3'd1, 32'h99, 1'b0, 32'h0);
    complete(3'd0, 32'h44, 1'b1, 32'h80);
    wb_valid_i = 1'b1; wb_idx_i = 3'd2; wb_result_i = 32'h77;
    alloc_valid_i = 1'b1; alloc_pc_i = 32'h700; alloc_instr_i = ~32'h700; alloc_rd_i = 5'd11;
    #1;
    chk("br_flush", {31'd0, flush_o}, 32'd1);
    chk("br_flush_pc", flush_pc_o, 32'h80);
    chk("br_one_lane", {30'd0, commit_valid_o}, 32'd1);
    tick();
    wb_valid_i = 1'b0; alloc_valid_i = 1'b0;
    lookup(5'd9, 5'd11);
    chk("post_flush_pulse", {31'd0, flush_o}, 32'd0);
    chk("post_flush_alloc_idx", {29'd0, alloc_idx_o}, 32'd0);
    chk("post_flush_full", {31'd0, full_o}, 32'd0);
    chk("post_flush_hazard", {30'd0, src_hazard_o}, 32'd0);
    chk("post_flush_commit", {30'd0, commit_valid_o}, 32'd0);

    // ---- rd = 0 retires without a register write ----
    do_reset();
    alloc(32'h600, 5'd0, 1'b1, 1'b0);
    lookup(5'd0, 5'd0);
    chk("x0_hazard", {30'd0, src_hazard_o}, 32'd0);
    push(0, 32'h600, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    complete(3'd0, 32'h1234, 1'b0, 32'h0);
    tick();
    tick();

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
